// File: rtl/conv1d_stream_engine.sv
// conv1d_stream_engine: streaming multi-channel 1D correlation with weight load, run and drain phases
module conv1d_stream_engine #(
  parameter int Data_Width_In     = 8,
  parameter int Kernel_Addr_Width = 2,
  parameter int Kernel_Size       = 1 << Kernel_Addr_Width,
  parameter int Out_Channels      = 2,
  parameter int Data_Width_Out    = 2*Data_Width_In+Kernel_Addr_Width,
  parameter int Len_Width         = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   cfg_reload,
  input  logic                                   cfg_stride2,
  input  logic [Len_Width-1:0]                   cfg_len,
  input  logic                                   w_valid,
  input  logic [Out_Channels*Data_Width_In-1:0]  w_data,
  output logic                                   w_ready,
  input  logic                                   in_valid,
  input  logic [Data_Width_In-1:0]               in_data,
  output logic                                   in_ready,
  output logic                                   out_valid,
  output logic [Out_Channels*Data_Width_Out-1:0] out_data,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);
  localparam int K = Kernel_Size;
  localparam int C = Out_Channels;
  localparam int DWI = Data_Width_In;
  localparam int DWO = Data_Width_Out;
  localparam logic [Len_Width-1:0] KM1 = Len_Width'(K-1);
  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [K-1:0][C-1:0][DWI-1:0] w_q, w_d;
  logic [K-1:0][DWI-1:0] win_q, win_d;
  logic [Kernel_Addr_Width-1:0] wcnt_q, wcnt_d;
  logic [Len_Width-1:0] n_q, n_d, len_q, len_d;
  logic stride_q, stride_d, out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
  logic [C*DWO-1:0] out_data_q, out_data_d;
  logic w_hs, in_hs, fire;
  logic signed [2*DWI-1:0] p;
  logic signed [DWO-1:0] acc;
  assign w_ready = state_q == LOAD_W;
  assign in_ready = state_q == RUN && (!out_valid_q || out_ready);
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign done = done_q;
  assign err = err_q;
  assign w_hs = w_valid && w_ready;
  assign in_hs = in_valid && in_ready;
  // stride 2 keeps only windows whose start offset m = n-(K-1) is even
  assign fire = in_hs && n_q >= KM1 && !(stride_q && (n_q[0] != KM1[0]));
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    win_d = win_q;
    wcnt_d = wcnt_q;
    n_d = n_q;
    len_d = len_q;
    stride_d = stride_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    done_d = 1'b0;
    err_d = 1'b0;
    p = '0;
    acc = '0;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_len < Len_Width'(K)) err_d = 1'b1;
        else begin
          state_d = cfg_reload ? LOAD_W : RUN;
          len_d = cfg_len;
          stride_d = cfg_stride2;
          n_d = '0;
          wcnt_d = '0;
        end
      end
      LOAD_W: if (w_hs) begin
        w_d[wcnt_q] = w_data;
        wcnt_d = wcnt_q + 1'b1;
        state_d = wcnt_q == Kernel_Addr_Width'(K-1) ? RUN : LOAD_W;
      end
      RUN: if (in_hs) begin
        win_d = {in_data, win_q[K-1:1]};
        n_d = n_q + 1'b1;
        state_d = n_q == len_q - 1'b1 ? DRAIN : RUN;
      end
      DRAIN: if (!out_valid_q) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      out_valid_d = 1'b1;
      for (int c = 0; c < C; c++) begin
        acc = '0;
        for (int k = 0; k < K; k++) begin
          p = $signed(w_q[k][c]) * $signed(win_d[k]);
          acc = acc + DWO'(p);
        end
        out_data_d[c*DWO +: DWO] = acc;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      w_q <= '0;
      win_q <= '0;
      wcnt_q <= '0;
      n_q <= '0;
      len_q <= '0;
      stride_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      win_q <= win_d;
      wcnt_q <= wcnt_d;
      n_q <= n_d;
      len_q <= len_d;
      stride_q <= stride_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_conv1d_stream_engine.sv
// tb_conv1d_stream_engine: randomized scoreboard bench with a direct correlation model
module tb_conv1d_stream_engine;
  localparam int K = 4, C = 2, DWI = 8, DWO = 18, LW = 8;
  logic clk = 1'b0, reset, start, cfg_reload, cfg_stride2;
  logic [LW-1:0] cfg_len;
  logic w_valid, w_ready, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [C*DWI-1:0] w_data;
  logic [DWI-1:0] in_data;
  logic [C*DWO-1:0] out_data;
  logic [C*DWO-1:0] sb[$];
  int compared = 0, mism = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0, stall = 0;
  bit stall_arm = 0, rnd_ready = 0;
  int wm[C][K];
  int wnew[C][K];
  int xs[$];
  always #5 clk = ~clk;
  conv1d_stream_engine dut (
    .clk(clk), .reset(reset), .start(start), .cfg_reload(cfg_reload), .cfg_stride2(cfg_stride2),
    .cfg_len(cfg_len), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mism++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  task automatic tick(inout int t);
    @(negedge clk);
    #2;
    t++;
    if (t > 500) begin
      $display("FAIL timeout: no handshake/done within 500 cycles");
      $fatal(1);
    end
  endtask
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_arm && out_valid) begin
        stall = 5;
        stall_arm = 0;
      end
      out_ready = stall > 0 ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (stall > 0) stall--;
      #1;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (w_ready) wr_cnt++;
      if (out_valid && !out_ready) chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else chk("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end
  task automatic run_job(input bit rl, input bit s2, input int len, input int ab);
    int dc0, t, y, v;
    logic [C*DWO-1:0] e;
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_reload = rl; cfg_stride2 = s2; cfg_len = LW'(len);
    @(negedge clk);
    start = 1'b0; cfg_len = LW'($urandom); cfg_stride2 = 1'($urandom);
    if (rl) begin
      for (int j = 0; j < K; j++) begin
        for (int c = 0; c < C; c++) begin
          wm[c][j] = wnew[c][j];
          v = wnew[c][j];
          w_data[c*DWI +: DWI] = v[DWI-1:0];
        end
        w_valid = 1'b1;
        #2;
        t = 0;
        while (!w_ready) tick(t);
        @(negedge clk);
      end
      w_valid = 1'b0;
    end
    for (int m = 0; m + K <= len; m += (s2 ? 2 : 1)) begin
      for (int c = 0; c < C; c++) begin
        y = 0;
        for (int k = 0; k < K; k++) y += wm[c][k] * xs[m+k];
        e[c*DWO +: DWO] = y[DWO-1:0];
      end
      sb.push_back(e);
    end
    for (int n = 0; n < len; n++) begin
      if (n == ab) begin
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_data", 64'(out_data), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'({w_ready, in_ready, done, err}), 64'd0);
        sb.delete();
        for (int c = 0; c < C; c++) for (int k = 0; k < K; k++) wm[c][k] = 0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      v = xs[n];
      in_data = v[DWI-1:0];
      in_valid = 1'b1;
      #2;
      t = 0;
      while (!in_ready) tick(t);
      @(negedge clk);
    end
    in_valid = 1'b0;
    t = 0;
    while (done_cnt == dc0) tick(t);
    repeat (3) @(negedge clk);
    #2;
    chk("done_once", 64'(done_cnt - dc0), 64'd1);
    chk("all_results_seen", 64'(sb.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask
  task automatic set_test1;
    wnew[0] = '{1, 2, 3, 4};
    wnew[1] = '{-1, 0, 0, 1};
    xs.delete();
    for (int i = 1; i <= 8; i++) xs.push_back(i);
  endtask
  task automatic rand_xs(input int len);
    xs.delete();
    for (int i = 0; i < len; i++) xs.push_back(int'($urandom_range(0, 255)) - 128);
  endtask
  initial begin
    int wr0, e0, len;
    reset = 1'b1; start = 1'b0; cfg_reload = 1'b0; cfg_stride2 = 1'b0; cfg_len = '0;
    w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < C; c++) for (int k = 0; k < K; k++) wm[c][k] = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    reset = 1'b0;
    set_test1;
    run_job(1, 0, 8, -1);
    wr0 = wr_cnt;
    run_job(0, 1, 8, -1);
    chk("reuse_no_w_ready", 64'(wr_cnt), 64'(wr0));
    for (int c = 0; c < C; c++) for (int k = 0; k < K; k++) wnew[c][k] = -128;
    xs = '{-128, -128, -128, -128};
    run_job(1, 0, 4, -1);
    set_test1;
    stall_arm = 1;
    run_job(1, 0, 8, -1);
    @(negedge clk);
    e0 = err_cnt;
    start = 1'b1; cfg_len = 8'd3; cfg_reload = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("short_err_pulse", 64'(err_cnt - e0), 64'd1);
    chk("short_busy", 64'(busy), 64'd0);
    chk("short_ready", 64'({w_ready, in_ready}), 64'd0);
    @(negedge clk);
    #2;
    chk("short_err_single", 64'(err_cnt - e0), 64'd1);
    rand_xs(4);
    run_job(0, 0, 4, -1);
    rnd_ready = 1;
    repeat (8) begin
      for (int c = 0; c < C; c++) for (int k = 0; k < K; k++) wnew[c][k] = int'($urandom_range(0, 255)) - 128;
      len = int'($urandom_range(K, 24));
      rand_xs(len);
      run_job(1'($urandom), 1'($urandom), len, -1);
    end
    rnd_ready = 0;
    set_test1;
    run_job(1, 0, 8, 3);
    rand_xs(8);
    run_job(0, 0, 8, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
